// File: rtl/uart_pkg.sv
// Shared constants for the UART bus-master bridge: simple_uart register map,
// status-register bit positions, bridge FSM encodings and the RX FIFO entry.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BUS_W  = 32;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned OVR_W  = 8;
    localparam int unsigned ST_W   = 3;

    // simple_uart register map
    localparam logic [ADDR_W-1:0] ADDR_ODR = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_IDR = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_BSR = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_SR  = 2'd3;

    // status register bits
    localparam int unsigned SR_TX_BUSY   = 0;
    localparam int unsigned SR_RX_RCVD   = 1;
    localparam int unsigned SR_FRAME_ERR = 2;

    // bridge FSM states
    typedef logic [ST_W-1:0] state_t;
    localparam state_t ST_INIT     = 3'd0;
    localparam state_t ST_IDLE     = 3'd1;
    localparam state_t ST_RD_SR    = 3'd2;
    localparam state_t ST_WAIT_SR  = 3'd3;
    localparam state_t ST_RD_IDR   = 3'd4;
    localparam state_t ST_WAIT_IDR = 3'd5;
    localparam state_t ST_CLR      = 3'd6;
    localparam state_t ST_WR_ODR   = 3'd7;

    // RX FIFO payload: received byte plus its frame-error flag
    typedef struct packed {
        logic              fe;
        logic [BYTE_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk_i/rst_i (async active-high), push_i/data_i write side,
// pop_i read side, data_o head entry (zero when empty), full_o, empty_o.
// A push while full is accepted only if a pop happens in the same cycle.
module uart_byte_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // extra pointer MSB separates full from empty
    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        data_o   = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // storage needs no reset; the output is masked while empty
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Bus master in front of simple_uart: programs the baud register once, then
// polls status, drains received bytes into an RX FIFO and feeds TX FIFO bytes
// to the UART when its transmitter is idle.
// Ports: clk_i/rst_i (async active-high); tx_* CPU push side; rx_* CPU pop
// side with frame-error flag and saturating overrun count; u_* UART register
// port (u_data_i is the UART's registered read data, valid one cycle later).
module uart_fifo_bridge
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter logic [31:0] BSR_INIT = 32'd2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [BYTE_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [BYTE_W-1:0] rx_data_o,
    output logic              rx_fe_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic [OVR_W-1:0]  rx_overrun_o,
    output logic              u_sel_o,
    output logic              u_we_o,
    output logic [ADDR_W-1:0] u_addr_o,
    output logic [BUS_W-1:0]  u_data_o,
    input  logic [BUS_W-1:0]  u_data_i
);

    state_t              state_q, state_d;
    logic                sel_q, sel_d, we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BUS_W-1:0]    wdata_q, wdata_d;
    logic                fe_q, fe_d;
    logic [OVR_W-1:0]    ovr_q, ovr_d;

    logic                tx_push, tx_pop, tx_full, tx_empty, tx_avail;
    logic [BYTE_W-1:0]   tx_head, tx_next_byte;
    logic                rx_push, rx_pop, rx_full, rx_empty;
    rx_entry_t           rx_in, rx_head;
    logic                unused_hi;

    assign unused_hi = ^u_data_i[BUS_W-1:BYTE_W];

    // FIFO handshakes; the bridge pops TX in WR_ODR and pushes RX in WAIT_IDR
    always_comb begin
        tx_push      = tx_valid_i && !tx_full;
        tx_pop       = (state_q == ST_WR_ODR);
        // a byte being pushed into an empty FIFO is already eligible
        tx_avail     = !tx_empty || tx_push;
        tx_next_byte = tx_empty ? tx_data_i : tx_head;
        rx_push      = (state_q == ST_WAIT_IDR);
        rx_pop       = rx_ready_i && !rx_empty;
        rx_in.fe     = fe_q;
        rx_in.data   = u_data_i[BYTE_W-1:0];
    end

    uart_byte_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tx_push),
        .data_i  (tx_data_i),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    uart_byte_fifo #(.WIDTH($bits(rx_entry_t)), .DEPTH(DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rx_push),
        .data_i  (rx_in),
        .pop_i   (rx_pop),
        .data_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    // Next state plus the bus access of the destination state, so the
    // registered bus lines up with the state that owns the access. The baud
    // write cannot be shown during reset, so it lands in the cycle after INIT.
    always_comb begin
        state_d = state_q;
        sel_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = ADDR_ODR;
        wdata_d = '0;
        fe_d    = fe_q;
        ovr_d   = ovr_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_IDLE;
                sel_d   = 1'b1;
                we_d    = 1'b1;
                addr_d  = ADDR_BSR;
                wdata_d = BSR_INIT;
            end
            ST_IDLE: begin
                state_d = ST_RD_SR;
                sel_d   = 1'b1;
                addr_d  = ADDR_SR;
            end
            ST_RD_SR: state_d = ST_WAIT_SR;
            ST_WAIT_SR: begin
                fe_d = u_data_i[SR_FRAME_ERR];
                if (u_data_i[SR_RX_RCVD]) begin
                    state_d = ST_RD_IDR;
                    sel_d   = 1'b1;
                    addr_d  = ADDR_IDR;
                end else if (!u_data_i[SR_TX_BUSY] && tx_avail) begin
                    state_d = ST_WR_ODR;
                    sel_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = ADDR_ODR;
                    wdata_d = {(BUS_W-BYTE_W)'(0), tx_next_byte};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_IDR: state_d = ST_WAIT_IDR;
            ST_WAIT_IDR: begin
                state_d = ST_CLR;
                sel_d   = 1'b1;
                we_d    = 1'b1;
                addr_d  = ADDR_SR;
                // byte dropped when full and the CPU is not freeing a slot
                if (rx_full && !rx_pop && (ovr_q != '1)) begin
                    ovr_d = ovr_q + OVR_W'(1);
                end
            end
            ST_CLR:    state_d = ST_IDLE;
            ST_WR_ODR: state_d = ST_IDLE;
            default:   state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            fe_q    <= 1'b0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        u_sel_o      = sel_q;
        u_we_o       = we_q;
        u_addr_o     = addr_q;
        u_data_o     = wdata_q;
        tx_ready_o   = !tx_full;
        rx_valid_o   = !rx_empty;
        rx_data_o    = rx_head.data;
        rx_fe_o      = rx_head.fe;
        rx_overrun_o = ovr_q;
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge with a behavioural simple_uart model.
module tb_uart_fifo_bridge;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BSR   = 32'd2;

    logic        clk;
    logic        rst_i;
    logic [7:0]  tx_data_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic [7:0]  rx_data_o;
    logic        rx_fe_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic [7:0]  rx_overrun_o;
    logic        u_sel_o;
    logic        u_we_o;
    logic [1:0]  u_addr_o;
    logic [31:0] u_data_o;
    logic [31:0] u_data_i;

    int total = 0;
    int bad   = 0;

    uart_fifo_bridge #(.DEPTH(DEPTH), .BSR_INIT(BSR)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .tx_data_i    (tx_data_i),
        .tx_valid_i   (tx_valid_i),
        .tx_ready_o   (tx_ready_o),
        .rx_data_o    (rx_data_o),
        .rx_fe_o      (rx_fe_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .rx_overrun_o (rx_overrun_o),
        .u_sel_o      (u_sel_o),
        .u_we_o       (u_we_o),
        .u_addr_o     (u_addr_o),
        .u_data_o     (u_data_o),
        .u_data_i     (u_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- UART model ----------------
    logic       m_rx, m_fe, m_busy;
    logic [7:0] m_idr;
    logic       rx_inject, inj_fe, busy_set, busy_clr;
    logic [7:0] inj_byte;
    int         wr_cnt [4];
    logic [31:0] last_wdata [4];
    int         cyc, last_sr, sr_gap;

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            m_rx <= 1'b0; m_fe <= 1'b0; m_busy <= 1'b0; m_idr <= 8'h00;
            u_data_i <= 32'h0;
            cyc <= 0; last_sr <= 0; sr_gap <= 0;
            for (int i = 0; i < 4; i++) begin
                wr_cnt[i]     <= 0;
                last_wdata[i] <= 32'h0;
            end
        end else begin
            cyc <= cyc + 1;
            if (busy_clr) m_busy <= 1'b0;
            if (busy_set) m_busy <= 1'b1;
            if (rx_inject) begin
                m_rx <= 1'b1; m_fe <= inj_fe; m_idr <= inj_byte;
            end
            if (u_sel_o) begin
                if (u_we_o) begin
                    wr_cnt[u_addr_o]     <= wr_cnt[u_addr_o] + 1;
                    last_wdata[u_addr_o] <= u_data_o;
                    if (u_addr_o == 2'd3) begin m_rx <= 1'b0; m_fe <= 1'b0; end
                    if (u_addr_o == 2'd0) m_busy <= 1'b1;
                end else begin
                    case (u_addr_o)
                        2'd3: begin
                            u_data_i <= {29'h0, m_fe, m_rx, m_busy};
                            sr_gap   <= cyc - last_sr;
                            last_sr  <= cyc;
                        end
                        2'd1:    u_data_i <= {24'h0, m_idr};
                        default: u_data_i <= 32'h0;
                    endcase
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_wr(input int a, input int base, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (wr_cnt[a] != base) begin ok = 1'b1; break; end
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk); tx_data_i = b; tx_valid_i = 1'b1;
        @(negedge clk); tx_valid_i = 1'b0;
    endtask

    task automatic pop_rx();
        @(negedge clk); rx_ready_i = 1'b1;
        @(negedge clk); rx_ready_i = 1'b0;
    endtask

    task automatic pulse_busy_clr();
        @(negedge clk); busy_clr = 1'b1;
        @(negedge clk); busy_clr = 1'b0;
    endtask

    task automatic inject(input logic fe, input logic [7:0] b);
        @(negedge clk); rx_inject = 1'b1; inj_fe = fe; inj_byte = b;
        @(negedge clk); rx_inject = 1'b0;
    endtask

    // inject one byte and wait for its CLR write
    task automatic rx_service(input logic fe, input logic [7:0] b);
        int base; bit ok;
        base = wr_cnt[3];
        inject(fe, b);
        wait_wr(3, base, 16, ok);
        chk("rx_clr_seen", 32'(ok), 32'd1);
    endtask

    // baud write right after reset release, then idle poll every 3 cycles
    task automatic boot_check();
        @(negedge clk);
        chk("boot_bus", {u_sel_o, u_we_o, 28'h0, u_addr_o}, {1'b1, 1'b1, 28'h0, 2'd2});
        chk("boot_bsr", u_data_o, BSR);
        repeat (12) @(negedge clk);
        chk("bsr_once", 32'(wr_cnt[2]), 32'd1);
        chk("poll_gap", 32'(sr_gap), 32'd3);
        chk("boot_tx_ready", 32'(tx_ready_o), 32'd1);
        chk("boot_rx_valid", 32'(rx_valid_o), 32'd0);
    endtask

    typedef struct {
        logic       fe;
        logic [7:0] b;
        logic [7:0] exp_d;
        logic       exp_fe;
    } rx_vec_t;

    typedef struct {
        logic [7:0]  b;
        logic [31:0] exp_w;
    } tx_vec_t;

    rx_vec_t rx_vec [4];
    tx_vec_t tx_vec [4];

    initial begin
        bit ok, found;
        int base, base_c;
        logic [31:0] got;

        rx_vec[0] = '{1'b0, 8'hA3, 8'hA3, 1'b0};
        rx_vec[1] = '{1'b1, 8'h7E, 8'h7E, 1'b1};
        rx_vec[2] = '{1'b0, 8'h00, 8'h00, 1'b0};
        rx_vec[3] = '{1'b1, 8'hC4, 8'hC4, 1'b1};
        tx_vec[0] = '{8'h00, 32'h0000_0000};
        tx_vec[1] = '{8'hFF, 32'h0000_00FF};
        tx_vec[2] = '{8'h3C, 32'h0000_003C};
        tx_vec[3] = '{8'hA5, 32'h0000_00A5};

        rst_i = 1'b1; tx_data_i = 8'h00; tx_valid_i = 1'b0; rx_ready_i = 1'b0;
        rx_inject = 1'b0; inj_fe = 1'b0; inj_byte = 8'h00;
        busy_set = 1'b0; busy_clr = 1'b0;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_bus", {u_sel_o, u_we_o, 28'h0, u_addr_o}, 32'h0);
        chk("rst_wdata", u_data_o, 32'h0);
        chk("rst_tx_ready", 32'(tx_ready_o), 32'd1);
        chk("rst_rx", {23'h0, rx_valid_o, rx_fe_o, rx_data_o}, 32'h0);
        chk("rst_ovr", 32'(rx_overrun_o), 32'd0);
        rst_i = 1'b0;
        boot_check();

        // TX latency with idle UART
        @(negedge clk); tx_data_i = 8'h55; tx_valid_i = 1'b1;
        found = 1'b0; got = 32'hDEAD;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (n == 1) tx_valid_i = 1'b0;
            if (u_sel_o && u_we_o && u_addr_o == 2'd0) begin
                found = 1'b1; got = u_data_o; break;
            end
        end
        chk("tx_latency", 32'(found), 32'd1);
        chk("tx_odr_55", got, 32'h55);
        repeat (8) @(negedge clk);
        chk("tx_one_write", 32'(wr_cnt[0]), 32'd1);

        // TX vectors: held while busy, written after busy clears
        foreach (tx_vec[v]) begin
            base = wr_cnt[0];
            push_byte(tx_vec[v].b);
            repeat (9) @(negedge clk);
            chk("tx_held_busy", 32'(wr_cnt[0]), 32'(base));
            pulse_busy_clr();
            wait_wr(0, base, 10, ok);
            chk("tx_written", 32'(ok), 32'd1);
            chk("tx_odr_data", last_wdata[0], tx_vec[v].exp_w);
        end

        // RX vectors
        foreach (rx_vec[v]) begin
            rx_service(rx_vec[v].fe, rx_vec[v].b);
            chk("rx_valid", 32'(rx_valid_o), 32'd1);
            chk("rx_data", 32'(rx_data_o), 32'(rx_vec[v].exp_d));
            chk("rx_fe", 32'(rx_fe_o), 32'(rx_vec[v].exp_fe));
            pop_rx();
            chk("rx_empty_after_pop", 32'(rx_valid_o), 32'd0);
        end

        // RX has priority over a pending TX byte
        base = wr_cnt[0];
        push_byte(8'h99);
        base_c = wr_cnt[3];
        @(negedge clk); rx_inject = 1'b1; inj_fe = 1'b1; inj_byte = 8'h7E; busy_clr = 1'b1;
        @(negedge clk); rx_inject = 1'b0; busy_clr = 1'b0;
        wait_wr(3, base_c, 16, ok);
        chk("prio_clr_seen", 32'(ok), 32'd1);
        chk("prio_no_odr_yet", 32'(wr_cnt[0]), 32'(base));
        wait_wr(0, base, 10, ok);
        chk("prio_odr_seen", 32'(ok), 32'd1);
        chk("prio_odr_data", last_wdata[0], 32'h99);
        chk("prio_rx", {23'h0, rx_valid_o, rx_fe_o, rx_data_o}, {23'h0, 1'b1, 1'b1, 8'h7E});
        pop_rx();

        // RX overrun: fill, then two extra bytes are dropped but still cleared
        for (int i = 0; i < DEPTH; i++) rx_service(1'b0, 8'(i * 7 + 3));
        chk("ovr_zero_at_full", 32'(rx_overrun_o), 32'd0);
        base_c = wr_cnt[3];
        rx_service(1'b0, 8'hEE);
        rx_service(1'b1, 8'hEF);
        chk("ovr_count", 32'(rx_overrun_o), 32'd2);
        chk("ovr_clr_count", 32'(wr_cnt[3]), 32'(base_c + 2));
        for (int i = 0; i < DEPTH; i++) begin
            chk("ovr_drain", {23'h0, rx_valid_o, rx_fe_o, rx_data_o},
                {23'h0, 1'b1, 1'b0, 8'(i * 7 + 3)});
            pop_rx();
        end
        chk("ovr_drained", 32'(rx_valid_o), 32'd0);

        // TX full: DEPTH+1 pushes while busy, the last one is ignored
        @(negedge clk); busy_set = 1'b1;
        @(negedge clk); busy_set = 1'b0;
        base = wr_cnt[0];
        for (int i = 0; i <= DEPTH; i++) begin
            @(negedge clk);
            if (i == DEPTH - 1) chk("tx_ready_before_full", 32'(tx_ready_o), 32'd1);
            if (i == DEPTH)     chk("tx_ready_full", 32'(tx_ready_o), 32'd0);
            tx_data_i = 8'(8'h40 + i); tx_valid_i = 1'b1;
        end
        @(negedge clk); tx_valid_i = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            pulse_busy_clr();
            wait_wr(0, base + k, 10, ok);
            chk("txf_written", 32'(ok), 32'd1);
            chk("txf_data", last_wdata[0], 32'(8'h40 + k));
        end
        pulse_busy_clr();
        repeat (10) @(negedge clk);
        chk("txf_extra_ignored", 32'(wr_cnt[0]), 32'(base + DEPTH));
        chk("txf_ready_again", 32'(tx_ready_o), 32'd1);

        // reset asserted during RD_IDR
        rx_service(1'b0, 8'h5A);
        chk("pre_rst_rx_valid", 32'(rx_valid_o), 32'd1);
        inject(1'b0, 8'h11);
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (u_sel_o && !u_we_o && u_addr_o == 2'd1) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("rd_idr_seen", 32'(found), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_bus", {u_sel_o, u_we_o, 28'h0, u_addr_o}, 32'h0);
        chk("mid_rst_wdata", u_data_o, 32'h0);
        chk("mid_rst_rx_valid", 32'(rx_valid_o), 32'd0);
        chk("mid_rst_ovr", 32'(rx_overrun_o), 32'd0);
        @(negedge clk);
        @(negedge clk); rst_i = 1'b0;
        boot_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
